// File: rtl/scrambler_tx_66b.sv
// 64b/66b transmit scrambler (x^58 + x^39 + 1) with idle/error block insertion; optional TX_SCR_BYPASS_EN.
// Latency: one clk from accepting edge to data_out; out_valid is registered enable.
// Backpressure: data_ready = enable && !rst, no internal buffering; upstream holds data while ready is low.
module scrambler_tx_66b #(
    parameter int TX_DATA_WIDTH = 64,
    parameter int SCR_STATE_W   = 58,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TX_DATA_WIDTH-1:0]   data_in,
    input  logic [1:0]                 sync_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  logic                       enable,
`ifdef TX_SCR_BYPASS_EN
    input  logic                       scr_bypass,
`endif
    output logic [0:TX_DATA_WIDTH+1]   data_out,
    output logic                       out_valid,
    output logic                       idle_inserted,
    output logic                       hdr_err,
    output logic [CNT_WIDTH-1:0]       block_cnt
);

    if (TX_DATA_WIDTH != 64) begin : g_bad_width
        $error("scrambler_tx_66b supports only TX_DATA_WIDTH = 64");
    end

    localparam logic [1:0]               SYNC_CTRL = 2'b10;
    localparam logic [TX_DATA_WIDTH-1:0] IDLE_BLK  = TX_DATA_WIDTH'(64'h1E00_0000_0000_0000);
    localparam logic [TX_DATA_WIDTH-1:0] ERR_BLK   = TX_DATA_WIDTH'(64'h1E1E_1E1E_1E1E_1E1E);

    logic [SCR_STATE_W-1:0]   scr_state;
    logic [SCR_STATE_W-1:0]   scr_next;
    logic [1:0]               sel_sync;
    logic [TX_DATA_WIDTH-1:0] sel_payload;
    logic                     sel_idle;
    logic                     sel_err;
    logic [0:TX_DATA_WIDTH-1] scr_bits;
    logic [0:TX_DATA_WIDTH-1] out_payload;

    assign data_ready = enable && !rst;

    always_comb begin
        sel_sync    = SYNC_CTRL;
        sel_payload = IDLE_BLK;
        sel_idle    = 1'b1;
        sel_err     = 1'b0;
        if (data_valid) begin
            sel_idle = 1'b0;
            if (sync_in == 2'b01 || sync_in == 2'b10) begin
                sel_sync    = sync_in;
                sel_payload = data_in;
            end else begin
                sel_payload = ERR_BLK;
                sel_err     = 1'b1;
            end
        end
    end

    // Bit k of the block goes on the wire k-th, so payload MSB is scrambled first.
    always_comb begin
        scr_next = scr_state;
        scr_bits = '0;
        for (int k = 0; k < TX_DATA_WIDTH; k++) begin
            scr_next    = {scr_next[SCR_STATE_W-2:0],
                           sel_payload[TX_DATA_WIDTH-1-k] ^ scr_next[38] ^ scr_next[57]};
            scr_bits[k] = scr_next[0];
        end
    end

`ifdef TX_SCR_BYPASS_EN
    // Ascending-range copy maps payload[63] to wire index 0.
    assign out_payload = scr_bypass ? sel_payload : scr_bits;
`else
    assign out_payload = scr_bits;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scr_state     <= '1;
            data_out      <= '0;
            out_valid     <= 1'b0;
            idle_inserted <= 1'b0;
            hdr_err       <= 1'b0;
            block_cnt     <= '0;
        end else begin
            out_valid     <= enable;
            idle_inserted <= enable && sel_idle;
            if (enable) begin
                scr_state <= scr_next;
                data_out  <= {sel_sync, out_payload};
                block_cnt <= block_cnt + CNT_WIDTH'(1);
                if (sel_err) begin
                    hdr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scrambler_tx_66b.sv
// Bench for scrambler_tx_66b: directed and random blocks against a line-history scrambler/descrambler model.
module tb_scrambler_tx_66b;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [63:0]   data_in;
    logic [1:0]    sync_in;
    logic          data_valid;
    logic          data_ready;
    logic          enable;
    logic [0:65]   data_out;
    logic          out_valid;
    logic          idle_inserted;
    logic          hdr_err;
    logic [CW-1:0] block_cnt;
`ifdef TX_SCR_BYPASS_EN
    logic          scr_bypass;
`endif

    scrambler_tx_66b #(.CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .sync_in(sync_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .enable(enable),
`ifdef TX_SCR_BYPASS_EN
        .scr_bypass(scr_bypass),
`endif
        .data_out(data_out),
        .out_valid(out_valid),
        .idle_inserted(idle_inserted),
        .hdr_err(hdr_err),
        .block_cnt(block_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Line history: most recent transmitted/received scrambled bit is at the back.
    bit tx_hist[$];
    bit rx_hist[$];

    logic [0:65]   exp_out;
    logic [CW-1:0] exp_cnt;
    logic          exp_hdr;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic seed_model();
        tx_hist = {};
        rx_hist = {};
        for (int i = 0; i < 58; i++) begin
            tx_hist.push_back(1'b1);
            rx_hist.push_back(1'b1);
        end
        exp_out = '0;
        exp_cnt = '0;
        exp_hdr = 1'b0;
    endtask

    // Line bit n = payload bit ^ line bit n-39 ^ line bit n-58.
    function automatic logic [0:63] tx_model(input logic [63:0] p);
        logic [0:63] r;
        bit s;
        for (int k = 0; k < 64; k++) begin
            s = p[63-k] ^ tx_hist[tx_hist.size()-39] ^ tx_hist[tx_hist.size()-58];
            tx_hist.push_back(s);
            r[k] = s;
        end
        while (tx_hist.size() > 58) void'(tx_hist.pop_front());
        return r;
    endfunction

    function automatic logic [63:0] rx_model(input logic [0:63] r);
        logic [63:0] d;
        for (int k = 0; k < 64; k++) begin
            d[63-k] = r[k] ^ rx_hist[rx_hist.size()-39] ^ rx_hist[rx_hist.size()-58];
            rx_hist.push_back(r[k]);
        end
        while (rx_hist.size() > 58) void'(rx_hist.pop_front());
        return d;
    endfunction

    task automatic cycle(input bit en, input bit vld, input logic [1:0] sy,
                         input logic [63:0] d, input bit byp);
        logic [1:0]  bsync;
        logic [63:0] bpay;
        logic [0:63] bits;
        logic [0:63] raw;
        logic [0:63] got;
        bit          exp_idle;
        enable     = en;
        data_valid = vld;
        sync_in    = sy;
        data_in    = d;
`ifdef TX_SCR_BYPASS_EN
        scr_bypass = byp;
`endif
        #1;
        check("data_ready", 66'(data_ready), 66'(en));
        exp_idle = en && !vld;
        bsync = 2'b10;
        bpay  = 64'h1E00_0000_0000_0000;
        if (en) begin
            if (vld && (sy == 2'b01 || sy == 2'b10)) begin
                bsync = sy;
                bpay  = d;
            end else if (vld) begin
                bpay    = 64'h1E1E_1E1E_1E1E_1E1E;
                exp_hdr = 1'b1;
            end
            bits = tx_model(bpay);
            raw  = bpay;
            exp_out = byp ? {bsync, raw} : {bsync, bits};
            exp_cnt = exp_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
        check("data_out", data_out, exp_out);
        check("out_valid", 66'(out_valid), 66'(en));
        check("idle_inserted", 66'(idle_inserted), 66'(exp_idle));
        check("hdr_err", 66'(hdr_err), 66'(exp_hdr));
        check("block_cnt", 66'(block_cnt), 66'(exp_cnt));
        if (en) begin
            got = data_out[2:65];
            if (byp) begin
                rx_hist = tx_hist;
            end else begin
                check("loopback_payload", 66'(rx_model(got)), 66'(bpay));
                check("loopback_sync", 66'(data_out[0:1]), 66'(bsync));
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data_out", data_out, 66'h0);
        check("rst_out_valid", 66'(out_valid), 66'h0);
        check("rst_idle", 66'(idle_inserted), 66'h0);
        check("rst_hdr_err", 66'(hdr_err), 66'h0);
        check("rst_block_cnt", 66'(block_cnt), 66'h0);
        check("rst_data_ready", 66'(data_ready), 66'h0);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        data_valid = 1'b0;
        sync_in    = 2'b01;
        data_in    = '0;
`ifdef TX_SCR_BYPASS_EN
        scr_bypass = 1'b0;
`endif
        seed_model();
        #3;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three idles from reset.
        for (int i = 0; i < 3; i++) cycle(1, 0, 2'b01, 64'h0, 0);
        check("idle_cnt3", 66'(block_cnt), 66'd3);

        // Back-to-back data.
        cycle(1, 1, 2'b01, 64'h0123_4567_89AB_CDEF, 0);
        cycle(1, 1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        cycle(1, 1, 2'b01, 64'h0, 0);

        // Enable toggling with data held.
        cycle(1, 1, 2'b10, 64'hDEAD_BEEF_CAFE_F00D, 0);
        cycle(0, 1, 2'b10, 64'hDEAD_BEEF_CAFE_F00D, 0);
        cycle(1, 1, 2'b10, 64'hDEAD_BEEF_CAFE_F00D, 0);
        cycle(0, 1, 2'b10, 64'hDEAD_BEEF_CAFE_F00D, 0);

        // Random legal traffic with gaps.
        for (int i = 0; i < 40; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10,
                  {$urandom, $urandom}, 0);
        end

        // Illegal header then sticky hdr_err across legal blocks.
        cycle(1, 1, 2'b11, 64'h1111_2222_3333_4444, 0);
        cycle(1, 1, 2'b00, 64'h5555_6666_7777_8888, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 2'b01, {$urandom, $urandom}, 0);

        // Drive the counter up to its wrap point.
        while (exp_cnt != '1) cycle(1, 1, 2'b01, {$urandom, $urandom}, 0);
        cycle(1, 0, 2'b01, 64'h0, 0);
        check("cnt_wrapped", 66'(block_cnt), 66'h0);
        cycle(1, 1, 2'b10, 64'h0F0F_0F0F_0F0F_0F0F, 0);

        // Asynchronous reset mid-stream.
        enable     = 1'b1;
        data_valid = 1'b1;
        rst        = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        seed_model();
        cycle(1, 1, 2'b01, 64'h0123_4567_89AB_CDEF, 0);
        cycle(1, 1, 2'b01, {$urandom, $urandom}, 0);

`ifdef TX_SCR_BYPASS_EN
        cycle(1, 1, 2'b01, 64'hA5A5_A5A5_A5A5_A5A5, 1);
        cycle(1, 1, 2'b01, 64'h0123_4567_89AB_CDEF, 0);
        cycle(1, 1, 2'b10, {$urandom, $urandom}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
